// File: rtl/fc_score_streamer.sv
// fc_score_streamer: captures one frame of FC-layer scores in parallel and streams them
// as (value, index) pairs, two per beat, over valid/ready into the argmax comparator tree.
// An odd class count pads the last beat with the most negative score, tagged with the
// last real class index, so any max-compare still returns a real class.
module fc_score_streamer #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned IDX_SIZE    = 4,
    parameter int unsigned NUM_CLASSES = 10
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [NUM_CLASSES*WORD_SIZE-1:0] i_scores,
    output logic                             o_busy,
    output logic [WORD_SIZE-1:0]             o_x1,
    output logic [IDX_SIZE-1:0]              o_index_x1,
    output logic [WORD_SIZE-1:0]             o_x2,
    output logic [IDX_SIZE-1:0]              o_index_x2,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic                             o_out_last,
    output logic                             o_done
);

    localparam int unsigned NumBeats = (NUM_CLASSES + 1) / 2;
    localparam int unsigned KW       = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    // Source table sized to the full index range so every beat lookup stays in bounds.
    localparam int unsigned SrcLen   = 2 ** (KW + 1);
    localparam logic [WORD_SIZE-1:0] MinVal = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [WORD_SIZE-1:0] r_scores [NUM_CLASSES];
    logic [KW-1:0]        r_k;
    logic [WORD_SIZE-1:0] r_x1;
    logic [WORD_SIZE-1:0] r_x2;
    logic [IDX_SIZE-1:0]  r_idx1;
    logic [IDX_SIZE-1:0]  r_idx2;
    logic                 r_last;
    logic                 r_done;

    logic                 w_idle;
    logic                 w_capture;
    logic                 w_xfer;
    logic                 w_load;
    logic [WORD_SIZE-1:0] w_src [SrcLen];
    logic [KW-1:0]        w_beat;
    logic [KW:0]          w_lo_pos;
    logic [KW:0]          w_hi_pos;
    logic                 w_hi_real;
    logic                 w_last_next;

    assign w_idle    = (r_state == StIdle);
    assign w_capture = w_idle & i_start;
    assign w_xfer    = (r_state == StSend) & i_out_ready;
    assign w_load    = w_capture | (w_xfer & ~r_last);

    // Beat 0 is taken straight from the input so it is on the outputs the cycle after start.
    for (genvar g = 0; g < SrcLen; g++) begin : g_src
        if (g < NUM_CLASSES) begin : g_real
            assign w_src[g] = w_idle ? i_scores[g*WORD_SIZE +: WORD_SIZE] : r_scores[g];
        end else begin : g_pad
            assign w_src[g] = MinVal;
        end
    end

    assign w_beat      = w_idle ? '0 : r_k + KW'(1);
    assign w_lo_pos    = {w_beat, 1'b0};
    assign w_hi_pos    = {w_beat, 1'b1};
    assign w_hi_real   = (32'(w_hi_pos) < NUM_CLASSES);
    assign w_last_next = (w_beat == KW'(NumBeats - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    // Next-state: start leaves IDLE, the final transfer returns to it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StSend;
            StSend:  if (i_out_ready && r_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Frame capture; contents only matter after a start so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_scores[i] <= i_scores[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Beat registers: reload on start or non-final transfer, hold under backpressure
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k    <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_idx1 <= '0;
            r_idx2 <= '0;
            r_last <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_xfer & r_last;
            if (w_load) begin
                r_k    <= w_beat;
                r_x1   <= w_src[w_lo_pos];
                r_idx1 <= IDX_SIZE'(w_lo_pos);
                r_x2   <= w_src[w_hi_pos];
                // Padding slot repeats the last real class index.
                r_idx2 <= w_hi_real ? IDX_SIZE'(w_hi_pos) : IDX_SIZE'(w_lo_pos);
                r_last <= w_last_next;
            end else if (w_xfer && r_last) begin
                r_last <= 1'b0;
            end
        end
    end

    assign o_out_valid = (r_state == StSend);
    assign o_busy      = (r_state == StSend);
    assign o_x1        = r_x1;
    assign o_x2        = r_x2;
    assign o_index_x1  = r_idx1;
    assign o_index_x2  = r_idx2;
    assign o_out_last  = r_last;
    assign o_done      = r_done;

endmodule

// File: tb/tb_fc_score_streamer.sv
// Bench for fc_score_streamer: an even-count instance (10 classes) and an odd-count
// instance (5 classes) checked beat by beat against an expected pair list.
module tb_fc_score_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: 10 classes
    logic         a_start = 1'b0;
    logic [159:0] a_scores = '0;
    logic         a_busy, a_valid, a_last, a_done;
    logic         a_ready = 1'b0;
    logic [15:0]  a_x1, a_x2;
    logic [3:0]   a_i1, a_i2;

    fc_score_streamer #(.WORD_SIZE(16), .IDX_SIZE(4), .NUM_CLASSES(10)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_scores(a_scores),
        .o_busy(a_busy), .o_x1(a_x1), .o_index_x1(a_i1), .o_x2(a_x2), .o_index_x2(a_i2),
        .o_out_valid(a_valid), .i_out_ready(a_ready), .o_out_last(a_last), .o_done(a_done)
    );

    // Instance B: 5 classes
    logic        b_start = 1'b0;
    logic [79:0] b_scores = '0;
    logic        b_busy, b_valid, b_last, b_done;
    logic        b_ready = 1'b0;
    logic [15:0] b_x1, b_x2;
    logic [3:0]  b_i1, b_i2;

    fc_score_streamer #(.WORD_SIZE(16), .IDX_SIZE(4), .NUM_CLASSES(5)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_scores(b_scores),
        .o_busy(b_busy), .o_x1(b_x1), .o_index_x1(b_i1), .o_x2(b_x2), .o_index_x2(b_i2),
        .o_out_valid(b_valid), .i_out_ready(b_ready), .o_out_last(b_last), .o_done(b_done)
    );

    function automatic logic [159:0] rand_a();
        logic [159:0] v;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    function automatic logic pick_ready(input int rmode, input int cyc);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Stream one frame on A. smode: 0 single start, 1 extra start pulse in beat 1,
    // 2 start held (next frame follows). pre: start for this frame already applied.
    task automatic stream_a(input logic [159:0] sc, input logic [159:0] nxt, input int rmode,
                            input int smode, input bit pre, input string tag);
        logic [15:0] ev[$];
        logic [3:0]  ei[$];
        logic [57:0] got, exp;
        logic        rdy;
        int          beat = 0;
        int          cyc = 0;
        for (int i = 0; i < 10; i++) begin
            ev.push_back(sc[i*16 +: 16]);
            ei.push_back(4'(i));
        end
        a_start = 1'b1;
        if (!pre) a_scores = sc;
        @(negedge clk);
        a_start  = (smode == 2);
        a_scores = nxt;
        while (beat < 5 && cyc < 200) begin
            got = {a_valid, a_busy, a_x1, a_i1, a_x2, a_i2, a_last};
            exp = {1'b1, 1'b1, ev[2*beat], ei[2*beat], ev[2*beat+1], ei[2*beat+1],
                   1'(beat == 4)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s beat%0d cyc%0d: got %h want %h", tag, beat, cyc, got, exp);
            end
            rdy = pick_ready(rmode, cyc);
            a_ready = rdy;
            a_start = (smode == 2) || (smode == 1 && beat == 1);
            @(negedge clk);
            cyc++;
            if (rdy) beat++;
        end
        a_ready = 1'b0;
        n_checks++;
        if (beat != 5) begin
            n_fail++;
            $display("FAIL %s timeout: beats %0d want 5", tag, beat);
        end
        n_checks++;
        if ({a_done, a_valid, a_busy, a_last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b want 1000", tag,
                     {a_done, a_valid, a_busy, a_last});
        end
        if (smode != 2) begin
            a_start = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({a_done, a_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s done_once: got %b want 00", tag, {a_done, a_valid});
            end
        end
    endtask

    // Stream one frame on B; expected list pads odd counts with (most negative, last idx).
    task automatic stream_b(input logic [79:0] sc, input int rmode, input string tag);
        logic [15:0] ev[$];
        logic [3:0]  ei[$];
        logic [57:0] got, exp;
        logic        rdy;
        int          nb, beat = 0, cyc = 0;
        for (int i = 0; i < 5; i++) begin
            ev.push_back(sc[i*16 +: 16]);
            ei.push_back(4'(i));
        end
        if (ev.size() % 2 == 1) begin
            ev.push_back(16'h8000);
            ei.push_back(ei[ei.size()-1]);
        end
        nb = ev.size() / 2;
        b_start  = 1'b1;
        b_scores = sc;
        @(negedge clk);
        b_start  = 1'b0;
        b_scores = 80'($urandom);
        while (beat < nb && cyc < 200) begin
            got = {b_valid, b_busy, b_x1, b_i1, b_x2, b_i2, b_last};
            exp = {1'b1, 1'b1, ev[2*beat], ei[2*beat], ev[2*beat+1], ei[2*beat+1],
                   1'(beat == nb - 1)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s beat%0d cyc%0d: got %h want %h", tag, beat, cyc, got, exp);
            end
            rdy = pick_ready(rmode, cyc);
            b_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) beat++;
        end
        b_ready = 1'b0;
        n_checks++;
        if (beat != nb || {b_done, b_valid, b_last} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s end: beats %0d done/valid/last %b want %0d 100", tag, beat,
                     {b_done, b_valid, b_last}, nb);
        end
        @(negedge clk);
        n_checks++;
        if (b_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_once: got %b want 0", tag, b_done);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({a_valid, a_last, a_busy, a_done, a_x1, a_x2, a_i1, a_i2} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0",
                     {a_valid, a_last, a_busy, a_done, a_x1, a_x2, a_i1, a_i2});
        end
        n_checks++;
        if ({b_valid, b_last, b_busy, b_done, b_x1, b_x2, b_i1, b_i2} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0",
                     {b_valid, b_last, b_busy, b_done, b_x1, b_x2, b_i1, b_i2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [159:0] sc;
        for (int i = 0; i < 10; i++) sc[i*16 +: 16] = 16'(i * 3 - 7);
        stream_a(sc, rand_a(), 0, 0, 0, "basic");
    endtask

    task automatic test_backpressure();
        logic [159:0] sc;
        for (int i = 0; i < 10; i++) sc[i*16 +: 16] = 16'(i * 3 - 7);
        stream_a(sc, rand_a(), 1, 0, 0, "backpressure");
    endtask

    task automatic test_start_ignored();
        stream_a(rand_a(), rand_a(), 2, 1, 0, "start_ignored");
    endtask

    task automatic test_odd();
        stream_b({16'd7, 16'h8000, 16'd0, -16'sd3, 16'd100}, 0, "odd_fixed");
        for (int r = 0; r < 3; r++) stream_b(80'({$urandom, $urandom, $urandom}), 2, "odd_rand");
    endtask

    task automatic test_reset_mid_frame();
        a_ready  = 1'b1;
        a_start  = 1'b1;
        a_scores = rand_a();
        @(negedge clk);
        a_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_valid, a_busy, a_last, a_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 0000", {a_valid, a_busy, a_last, a_done});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        a_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({a_valid, a_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_quiet: got %b want 00", {a_valid, a_done});
            end
        end
        stream_a(rand_a(), rand_a(), 0, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [159:0] s1, s2;
        s1 = rand_a();
        s2 = rand_a();
        stream_a(s1, s2, 0, 2, 0, "b2b_f1");
        stream_a(s2, rand_a(), 2, 0, 1, "b2b_f2");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) stream_a(rand_a(), rand_a(), 2, 0, 0, "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_odd();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
